// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: iterative double-dabble binary-to-BCD converter with start/busy/done handshake
module bin_to_bcd_seq #(
    parameter int WIDTH    = 8,
    parameter bit BLANK_LZ = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [11:0]      bcd
);
    localparam int SW = WIDTH + 12;

    if (WIDTH < 4 || WIDTH > 9) begin : g_bad_width
        $error("bin_to_bcd_seq: WIDTH must be in 4..9");
    end

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] sr_q, sr_d, shifted;
    logic [3:0]    cnt_q, cnt_d;
    logic [11:0]   bcd_q, bcd_d, adj, fin, fin_bl;
    logic          done_q, done_d, last;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    always_comb begin
        adj     = {add3(sr_q[WIDTH+8 +: 4]), add3(sr_q[WIDTH+4 +: 4]), add3(sr_q[WIDTH +: 4])};
        shifted = {adj, sr_q[WIDTH-1:0]} << 1;
        fin     = shifted[SW-1 -: 12];
        // hundreds/tens blank only when every more-significant digit is also zero
        fin_bl  = {(BLANK_LZ && fin[11:8] == 4'd0) ? 4'hF : fin[11:8],
                   (BLANK_LZ && fin[11:4] == 8'd0) ? 4'hF : fin[7:4],
                   fin[3:0]};
        last    = cnt_q == 4'(WIDTH - 1);
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                sr_d    = {12'd0, bin};
                cnt_d   = 4'd0;
                state_d = SHIFT;
            end
        end else begin
            sr_d  = shifted;
            cnt_d = cnt_q + 4'd1;
            if (last) begin
                bcd_d   = fin_bl;
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= 4'd0;
            bcd_q   <= 12'h000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
        end
    end

    assign busy = state_q == SHIFT;
    assign done = done_q;
    assign bcd  = bcd_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed and sweep checks for bin_to_bcd_seq across three parameter sets
module tb_bin_to_bcd_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    logic [7:0]  bin0 = '0, bin1 = '0;
    logic [8:0]  bin2 = '0;
    logic        busy0, busy1, busy2, done0, done1, done2;
    logic [11:0] bcd0, bcd1, bcd2;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.WIDTH(8), .BLANK_LZ(1'b0)) u0 (.clk(clk), .reset(reset), .start(start0), .bin(bin0),
        .busy(busy0), .done(done0), .bcd(bcd0));
    bin_to_bcd_seq #(.WIDTH(8), .BLANK_LZ(1'b1)) u1 (.clk(clk), .reset(reset), .start(start1), .bin(bin1),
        .busy(busy1), .done(done1), .bcd(bcd1));
    bin_to_bcd_seq #(.WIDTH(9), .BLANK_LZ(1'b0)) u2 (.clk(clk), .reset(reset), .start(start2), .bin(bin2),
        .busy(busy2), .done(done2), .bcd(bcd2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int v, input bit bl);
        logic [3:0] h, t, u;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        if (bl && h == 4'd0) begin
            h = 4'hF;
            if (t == 4'd0) t = 4'hF;
        end
        return {h, t, u};
    endfunction

    // one conversion on unit sel; latency counted in falling edges after the start-driving edge
    task automatic conv(input int sel, input int v, input logic [11:0] exp);
        int n;
        @(negedge clk);
        if (sel == 0) begin start0 = 1'b1; bin0 = 8'(v); end
        else if (sel == 1) begin start1 = 1'b1; bin1 = 8'(v); end
        else begin start2 = 1'b1; bin2 = 9'(v); end
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        n = 1;
        while (!(sel == 0 ? done0 : sel == 1 ? done1 : done2) && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, (sel == 2) ? 10 : 9);
        chk("bcd", sel == 0 ? bcd0 : sel == 1 ? bcd1 : bcd2, exp);
    endtask

    initial begin
        int n, dn;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_bcd0", bcd0, 12'h000);
        chk("rst_bcd1", bcd1, 12'h000);
        reset = 1'b0;

        @(negedge clk);
        start0 = 1'b1; bin0 = 8'd255;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            start0 = 1'b0;
            chk("busy255", busy0, 1);
            chk("nodone255", done0, 0);
        end
        @(negedge clk);
        chk("busy_done255", busy0, 0);
        chk("done255", done0, 1);
        chk("bcd255", bcd0, 12'h255);
        @(negedge clk);
        chk("done_fall255", done0, 0);
        chk("hold255", bcd0, 12'h255);

        conv(0, 0, 12'h000);
        conv(1, 0, 12'hFF0);
        conv(1, 7, 12'hFF7);
        conv(1, 100, 12'h100);
        conv(1, 45, 12'hF45);

        @(negedge clk);
        start0 = 1'b1; bin0 = 8'd42;
        @(negedge clk);
        start0 = 1'b0;
        repeat (2) @(negedge clk);
        start0 = 1'b1; bin0 = 8'd99;
        @(negedge clk);
        start0 = 1'b0;
        n = 0;
        while (!done0 && n < 30) begin @(negedge clk); n++; end
        chk("ignored_start_bcd", bcd0, 12'h042);
        dn = 0;
        repeat (15) begin @(negedge clk); if (done0 || busy0) dn++; end
        chk("no_second_conv", dn, 0);

        @(negedge clk);
        start0 = 1'b1; bin0 = 8'd128;
        @(negedge clk);
        start0 = 1'b0;
        n = 1;
        while (!done0 && n < 30) begin @(negedge clk); n++; end
        chk("b2b_lat1", n, 9);
        chk("b2b_bcd1", bcd0, 12'h128);
        start0 = 1'b1; bin0 = 8'd9;
        @(negedge clk);
        start0 = 1'b0;
        n = 1;
        while (!done0 && n < 30) begin @(negedge clk); n++; end
        chk("b2b_period", n, 9);
        chk("b2b_bcd2", bcd0, 12'h009);

        conv(0, 55, 12'h055);
        @(negedge clk);
        start0 = 1'b1; bin0 = 8'd200;
        @(negedge clk);
        start0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_before_rst", busy0, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_busy", busy0, 0);
        chk("async_done", done0, 0);
        chk("async_bcd", bcd0, 12'h000);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        dn = 0;
        repeat (12) begin @(negedge clk); if (done0) dn++; end
        chk("no_done_after_rst", dn, 0);
        chk("bcd_after_rst", bcd0, 12'h000);
        conv(0, 200, 12'h200);

        for (int v = 0; v < 256; v++) conv(0, v, ref_bcd(v, 1'b0));
        for (int v = 0; v < 256; v++) conv(1, v, ref_bcd(v, 1'b1));
        for (int v = 0; v < 512; v++) conv(2, v, ref_bcd(v, 1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using the iterative double-dabble (shift-and-add-3) algorithm.
- Produces the 12-bit packed BCD word (hundreds/tens/units) consumed by the team's BCD-to-7-segment display path.
- Sits between the RISC-V core's display/output register and the 7-segment decoders.
- Uses a start/busy/done handshake. Converts one value per WIDTH+1 cycles.

Parameters:
- WIDTH, 8: binary input width. Legal range 4..9, so the maximum value (511) fits in 3 BCD digits. Elaboration error outside this range.
- BLANK_LZ, 0: when 1, leading-zero hundreds/tens digits are output as 4'hF, which the 7-seg decoder shows as blank. The units digit is never blanked.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a conversion. Sampled only while idle (busy=0).
- bin  input  WIDTH  unsigned binary value. Captured on the accepted start edge only.
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse: bcd has just been updated
- bcd  output  12  packed BCD {hundreds[11:8], tens[7:4], units[3:0]}. Holds its value until the next done.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high; it forces the state immediately, without waiting for a clock edge.
- Reset values: state=IDLE, busy=0, done=0, bcd=12'h000 (also 12'h000 when BLANK_LZ=1). Shift register and counter are cleared.
- Internal registers:
  - Shift register {scratch BCD[11:0], binary[WIDTH-1:0]}.
  - Iteration counter, 4 bits.
- State IDLE (busy=0):
  - start=1 at a clock edge: load binary<=bin, scratch<=0, counter<=0, go to SHIFT.
  - start=0: stay in IDLE.
- State SHIFT (busy=1), one iteration per clock:
  - Each BCD nibble of scratch that is >=5 gets +3. Nibbles are 4 bits and cannot overflow, because adjusted values are <=12.
  - Then the whole register shifts left by 1. The binary MSB enters scratch[0].
  - counter increments.
  - On the edge that performs iteration WIDTH (counter==WIDTH-1): bcd<=final scratch (with blanking if enabled), done<=1, go to IDLE.
- Latency: start accepted at edge E0; shifts at E1..E_WIDTH; done=1 and the new bcd are visible during cycle E_WIDTH..E_WIDTH+1. For WIDTH=8, done rises 8 cycles after the start edge.
- busy: high from E0+ through E_WIDTH-. Low during the done cycle.
- done: high for exactly one cycle, then cleared at the next edge.
- Blanking (BLANK_LZ=1), applied only at the bcd update:
  - If hundreds==0, hundreds<=4'hF.
  - If hundreds==0 and tens==0, tens<=4'hF.
  - Units digit is always kept.
- Boundary conditions:
  - start while busy=1: ignored, no queuing. The bin change has no effect on the conversion in progress.
  - start=1 in the done cycle: accepted, since the state is IDLE. Back-to-back conversions run with a period of WIDTH+1 cycles.
  - start held high continuously: a new conversion is started each time IDLE is reached.
  - bin changing mid-conversion: no effect.
  - reset asserted mid-conversion: immediate return to reset values. The previous bcd is lost (forced to 000), done is never pulsed, and a fresh start is required.
  - Output encoding: bcd digits are always 0..9, or 4'hF when blanked. No other codes are ever produced.

Test Plan:
- WIDTH=8, BLANK_LZ=0, bin=8'd255, 1-cycle start → busy high for 8 cycles; done pulses 8 cycles after the start edge; bcd=12'h255, held after done falls.
- bin=8'd0 with BLANK_LZ=0 → bcd=12'h000. Same input with BLANK_LZ=1 → bcd=12'hFF0. bin=8'd7, BLANK_LZ=1 → 12'hFF7. bin=8'd100, BLANK_LZ=1 → 12'h100.
- Start with bin=8'd42, then pulse start with bin=8'd99 while busy → bcd=12'h042; only one done pulse; no second conversion.
- start asserted during the done cycle of a bin=8'd128 conversion, with bin=8'd9 → first bcd=12'h128, next done exactly 9 cycles later with bcd=12'h009.
- Assert reset asynchronously 4 cycles into converting bin=8'd200 (previous bcd=12'h055) → busy, done and bcd drop to 0 immediately, with no clock edge needed; no done pulse. A subsequent start converts correctly.
- Exhaustive sweep of bin 0..255 (WIDTH=8) and 0..511 (WIDTH=9) against a reference model → every bcd matches the decimal digits; latency is constant at WIDTH cycles.
